// File: rtl/i2c_seq_pkg.sv
// i2c transfer sequencer: command codes shared with the byte engine
// and the sequencer state encoding.
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } i2cCmd_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_ADDR,
    S_WR_FETCH,
    S_WR_CMD,
    S_RD_CMD,
    S_RD_STORE,
    S_STOP,
    S_DONE
  } seqState_t;

  localparam int ADDRWIDTH = 7;

endpackage

// File: rtl/i2c_transfer_sequencer.sv
// i2c master transaction sequencer: START, address, N data bytes, STOP,
// one engine command outstanding at a time, fed from/to the byte FIFOs.
module i2c_transfer_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int COUNTWIDTH = 8,
  parameter int DATAWIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDRWIDTH-1:0]  slaveAddr,
  input  logic                  readNotWrite,
  input  logic [COUNTWIDTH-1:0] byteCount,
  output logic                  busy,
  output logic                  done,
  output logic                  nackError,
  output logic [COUNTWIDTH-1:0] bytesDone,
  input  logic                  txEmpty,
  input  logic [DATAWIDTH-1:0]  txData,
  output logic                  txReadReq,
  input  logic                  rxFull,
  output logic                  rxWriteEn,
  output logic [DATAWIDTH-1:0]  rxData,
  output logic                  cmdValid,
  input  logic                  cmdReady,
  output logic [1:0]            cmd,
  output logic [DATAWIDTH-1:0]  cmdData,
  output logic                  cmdNackLast,
  input  logic                  rspValid,
  input  logic                  rspAck,
  input  logic [DATAWIDTH-1:0]  rspData
);

  seqState_t              state;
  seqState_t              nxt;
  i2cCmd_t                cmdQ;
  logic [ADDRWIDTH-1:0]   addrQ;
  logic                   rnwQ;
  logic [COUNTWIDTH-1:0]  countQ;
  logic [COUNTWIDTH-1:0]  doneInc;
  logic [COUNTWIDTH-1:0]  rdBase;
  logic [COUNTWIDTH:0]    rdNext;
  logic                   rsp;
  logic                   lastByte;
  logic                   nackNext;

  assign busy     = (state != S_IDLE);
  assign cmd      = cmdQ;
  assign rsp      = rspValid && !cmdValid;
  assign doneInc  = bytesDone + COUNTWIDTH'(1);
  assign lastByte = (doneInc == countQ);

  // FIFO strobes are decoded from state so a pop/push can never
  // land on a cycle where the FIFO flag has already changed.
  assign txReadReq = reset && (state == S_WR_FETCH)
                     && !abort && !txEmpty;
  assign rxWriteEn = reset && (state == S_RD_STORE) && !rxFull;

  assign rdBase   = (state == S_RD_STORE) ? doneInc : '0;
  assign rdNext   = {1'b0, rdBase} + {{COUNTWIDTH{1'b0}}, 1'b1};
  assign nackNext = (rdNext == {1'b0, countQ});

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (start) nxt = S_START;
      S_START:
        if (rsp) nxt = abort ? S_STOP : S_ADDR;
      S_ADDR:
        if (rsp) begin
          if (!rspAck || countQ == '0 || abort) nxt = S_STOP;
          else if (rnwQ)                        nxt = S_RD_CMD;
          else                                  nxt = S_WR_FETCH;
        end
      S_WR_FETCH:
        if (abort)         nxt = S_STOP;
        else if (!txEmpty) nxt = S_WR_CMD;
      S_WR_CMD:
        if (rsp)
          nxt = (!rspAck || lastByte || abort) ? S_STOP : S_WR_FETCH;
      S_RD_CMD:
        if (rsp) nxt = S_RD_STORE;
      S_RD_STORE:
        if (!rxFull) nxt = (lastByte || abort) ? S_STOP : S_RD_CMD;
      S_STOP:
        if (rsp) nxt = S_DONE;
      S_DONE:
        nxt = S_IDLE;
      default:
        nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cmdQ        <= CMD_START;
      cmdValid    <= 1'b0;
      cmdData     <= '0;
      cmdNackLast <= 1'b0;
      rxData      <= '0;
      bytesDone   <= '0;
      nackError   <= 1'b0;
      done        <= 1'b0;
      addrQ       <= '0;
      rnwQ        <= 1'b0;
      countQ      <= '0;
    end else begin
      state <= nxt;
      done  <= (state == S_DONE);

      if (cmdValid && cmdReady) cmdValid <= 1'b0;

      if (state == S_IDLE && start) begin
        addrQ     <= slaveAddr;
        rnwQ      <= readNotWrite;
        countQ    <= byteCount;
        bytesDone <= '0;
        nackError <= 1'b0;
      end

      if (rsp && !rspAck &&
          (state == S_ADDR || state == S_WR_CMD))
        nackError <= 1'b1;

      if (rsp && state == S_WR_CMD) bytesDone <= doneInc;
      if (rxWriteEn)                bytesDone <= doneInc;
      if (rsp && state == S_RD_CMD) rxData    <= rspData;
      if (txReadReq)                cmdData   <= txData;

      // A new command is offered exactly on entry to a command state.
      if (nxt != state) begin
        cmdNackLast <= 1'b0;
        unique case (nxt)
          S_START: begin
            cmdValid <= 1'b1;
            cmdQ     <= CMD_START;
          end
          S_ADDR: begin
            cmdValid <= 1'b1;
            cmdQ     <= CMD_WRITE;
            cmdData  <= DATAWIDTH'({addrQ, rnwQ});
          end
          S_WR_CMD: begin
            cmdValid <= 1'b1;
            cmdQ     <= CMD_WRITE;
          end
          S_RD_CMD: begin
            cmdValid    <= 1'b1;
            cmdQ        <= CMD_READ;
            cmdNackLast <= nackNext;
          end
          S_STOP: begin
            cmdValid <= 1'b1;
            cmdQ     <= CMD_STOP;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_transfer_sequencer.sv
// Bench for i2c_transfer_sequencer: engine/FIFO models driven on the
// falling edge, command and rx byte scoreboards checked before each rise.
module tb_i2c_transfer_sequencer;
  import i2c_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [6:0] slaveAddr = '0;
  logic       readNotWrite = 1'b0;
  logic [7:0] byteCount = '0;
  logic       busy, done, nackError;
  logic [7:0] bytesDone;
  logic       txEmpty = 1'b1;
  logic [7:0] txData = '0;
  logic       txReadReq;
  logic       rxFull = 1'b0;
  logic       rxWriteEn;
  logic [7:0] rxData;
  logic       cmdValid;
  logic       cmdReady = 1'b1;
  logic [1:0] cmd;
  logic [7:0] cmdData;
  logic       cmdNackLast;
  logic       rspValid = 1'b0;
  logic       rspAck = 1'b0;
  logic [7:0] rspData = '0;

  always #5 clk = ~clk;

  i2c_transfer_sequencer #(.COUNTWIDTH(8), .DATAWIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .slaveAddr(slaveAddr), .readNotWrite(readNotWrite),
    .byteCount(byteCount), .busy(busy), .done(done),
    .nackError(nackError), .bytesDone(bytesDone),
    .txEmpty(txEmpty), .txData(txData), .txReadReq(txReadReq),
    .rxFull(rxFull), .rxWriteEn(rxWriteEn), .rxData(rxData),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmd(cmd),
    .cmdData(cmdData), .cmdNackLast(cmdNackLast),
    .rspValid(rspValid), .rspAck(rspAck), .rspData(rspData)
  );

  int tests = 0;
  int fails = 0;

  logic [10:0] expQ[$];
  logic [7:0]  txQ[$];
  logic [7:0]  rdQ[$];
  logic [7:0]  rxQ[$];

  logic hsSeen = 0, popSeen = 0, pend = 0;
  logic pAck = 0, addrNext = 0, nackAddr = 0;
  logic txBlock = 0, rxBlock = 0, readyBlock = 0;
  logic busyAtDone = 0;
  logic [7:0] pData = '0;
  int dly = 0, txPops = 0, rxPushes = 0, doneCnt = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] ent(input logic [1:0] c,
                                      input logic [7:0] d,
                                      input logic n);
    return {c, d, n};
  endfunction

  // Engine, TX FIFO and RX FIFO models.
  initial begin
    logic [10:0] got;
    forever begin
      @(negedge clk);
      if (popSeen && txQ.size() > 0) void'(txQ.pop_front());
      rspValid = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          rspValid = 1'b1;
          rspAck   = pAck;
          rspData  = pData;
          pend     = 1'b0;
        end else dly--;
      end
      if (hsSeen) begin
        pend = 1'b1;
        dly  = 1;
      end
      txEmpty  = txBlock || (txQ.size() == 0);
      txData   = (txQ.size() > 0) ? txQ[0] : 8'h00;
      rxFull   = rxBlock;
      cmdReady = !readyBlock;
      #4;
      hsSeen  = 1'b0;
      popSeen = 1'b0;
      if (!reset) begin
        pend     = 1'b0;
        addrNext = 1'b0;
      end else begin
        if (cmdValid && cmdReady) begin
          hsSeen = 1'b1;
          got = {cmd, (cmd == CMD_WRITE) ? cmdData : 8'h00,
                 (cmd == CMD_READ) ? cmdNackLast : 1'b0};
          if (expQ.size() == 0) check("cmd_extra", 0, 1);
          else check("cmd", 32'(got), 32'(expQ.pop_front()));
          pAck  = 1'b1;
          pData = 8'h00;
          if (cmd == CMD_START) addrNext = 1'b1;
          else if (cmd == CMD_WRITE && addrNext) begin
            addrNext = 1'b0;
            if (nackAddr) begin
              pAck     = 1'b0;
              nackAddr = 1'b0;
            end
          end else if (cmd == CMD_READ)
            pData = (rdQ.size() > 0) ? rdQ.pop_front() : 8'hEE;
        end
        popSeen = txReadReq;
        if (popSeen) txPops++;
        if (rxWriteEn) begin
          rxPushes++;
          if (rxQ.size() == 0) check("rx_extra", 0, 1);
          else check("rxdata", 32'(rxData), 32'(rxQ.pop_front()));
        end
        if (done) begin
          doneCnt++;
          busyAtDone = busy;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
    #4;
  endtask

  task automatic kick(input logic [6:0] a, input logic r,
                      input logic [7:0] n);
    @(negedge clk);
    slaveAddr    = a;
    readNotWrite = r;
    byteCount    = n;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    slaveAddr    = ~a;
    readNotWrite = ~r;
    byteCount    = 8'h00;
    #4;
    check("kick_busy", 32'(busy), 1);
    check("kick_cmd", 32'({cmdValid, cmd}), 32'(3'b100));
  endtask

  task automatic waitDone(input int base, input string tag);
    int i;
    i = 0;
    while (doneCnt == base && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_done"}, 32'(doneCnt != base), 1);
    check({tag, "_idle_on_done"}, 32'(busyAtDone), 0);
  endtask

  initial begin
    int base, p0, bad, i;
    logic [10:0] held;

    repeat (3) @(negedge clk);
    #4;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd", 32'({cmdValid, cmd, cmdData, cmdNackLast}), 0);
    check("rst_count", 32'({bytesDone, nackError, rxData}), 0);
    check("rst_strobes", 32'({txReadReq, rxWriteEn}), 0);
    @(negedge clk);
    reset = 1'b1;

    // Write 3 bytes to 0x50
    txQ = '{8'hA1, 8'hB2, 8'hC3};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA0, 0),
             ent(CMD_WRITE, 8'hA1, 0), ent(CMD_WRITE, 8'hB2, 0),
             ent(CMD_WRITE, 8'hC3, 0), ent(CMD_STOP, 0, 0)};
    base = doneCnt;
    p0 = txPops;
    kick(7'h50, 1'b0, 8'd3);
    waitDone(base, "wr3");
    check("wr3_bytes", 32'(bytesDone), 3);
    check("wr3_nack", 32'(nackError), 0);
    check("wr3_pops", txPops - p0, 3);
    check("wr3_left", expQ.size(), 0);
    repeat (3) tick();
    check("wr3_done_once", doneCnt - base, 1);
    check("wr3_busy_after", 32'(busy), 0);

    // Read 2 bytes from 0x50
    rdQ = '{8'h5A, 8'h6B};
    rxQ = '{8'h5A, 8'h6B};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA1, 0),
             ent(CMD_READ, 0, 0), ent(CMD_READ, 0, 1),
             ent(CMD_STOP, 0, 0)};
    base = doneCnt;
    p0 = rxPushes;
    kick(7'h50, 1'b1, 8'd2);
    waitDone(base, "rd2");
    check("rd2_bytes", 32'(bytesDone), 2);
    check("rd2_pushes", rxPushes - p0, 2);
    check("rd2_left", expQ.size() + rxQ.size(), 0);

    // Address NACK with byteCount 4
    nackAddr = 1'b1;
    txQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA0, 0),
             ent(CMD_STOP, 0, 0)};
    base = doneCnt;
    p0 = txPops;
    kick(7'h50, 1'b0, 8'd4);
    waitDone(base, "nack");
    check("nack_flag", 32'(nackError), 1);
    check("nack_bytes", 32'(bytesDone), 0);
    check("nack_pops", txPops - p0, 0);
    check("nack_left", expQ.size(), 0);
    txQ.delete();

    // TX underflow stall, then abort while stalled
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA0, 0),
             ent(CMD_WRITE, 8'h11, 0), ent(CMD_STOP, 0, 0)};
    base = doneCnt;
    p0 = txPops;
    kick(7'h50, 1'b0, 8'd2);
    check("stall_nack_cleared", 32'(nackError), 0);
    repeat (25) tick();
    check("stall_idle_cmd", 32'(cmdValid), 0);
    check("stall_busy", 32'(busy), 1);
    check("stall_bytes", 32'(bytesDone), 0);
    txQ.push_back(8'h11);
    i = 0;
    while (bytesDone != 8'd1 && i < 100) begin
      tick();
      i++;
    end
    check("stall_byte1", 32'(bytesDone), 1);
    repeat (3) tick();
    check("stall2_idle_cmd", 32'(cmdValid), 0);
    @(negedge clk);
    abort = 1'b1;
    waitDone(base, "abort");
    abort = 1'b0;
    check("abort_bytes", 32'(bytesDone), 1);
    check("abort_nack", 32'(nackError), 0);
    check("abort_pops", txPops - p0, 1);
    check("abort_left", expQ.size(), 0);

    // RX full stall plus cmdReady backpressure
    rdQ = '{8'h11, 8'h22, 8'h33};
    rxQ = '{8'h11, 8'h22, 8'h33};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA1, 0),
             ent(CMD_READ, 0, 0), ent(CMD_READ, 0, 0),
             ent(CMD_READ, 0, 1), ent(CMD_STOP, 0, 0)};
    rxBlock = 1'b1;
    base = doneCnt;
    p0 = rxPushes;
    kick(7'h50, 1'b1, 8'd3);
    repeat (30) tick();
    readyBlock = 1'b1;
    bad = 0;
    repeat (10) begin
      tick();
      if (rxWriteEn || cmdValid) bad++;
    end
    check("rxfull_quiet", bad, 0);
    check("rxfull_nopush", rxPushes - p0, 0);
    rxBlock = 1'b0;
    i = 0;
    while (!cmdValid && i < 20) begin
      tick();
      i++;
    end
    check("bp_offer", 32'({cmdValid, cmd}), 32'(3'b110));
    held = {cmd, cmdData, cmdNackLast};
    bad = 0;
    repeat (5) begin
      tick();
      if ({cmdValid, cmd, cmdData, cmdNackLast} != {1'b1, held}) bad++;
    end
    check("bp_hold", bad, 0);
    readyBlock = 1'b0;
    waitDone(base, "rd3");
    check("rd3_bytes", 32'(bytesDone), 3);
    check("rd3_pushes", rxPushes - p0, 3);
    check("rd3_left", expQ.size() + rxQ.size(), 0);

    // Reset after the second write byte, then a fresh transfer
    txQ = '{8'h01, 8'h02, 8'h03, 8'h04};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'hA0, 0),
             ent(CMD_WRITE, 8'h01, 0), ent(CMD_WRITE, 8'h02, 0),
             ent(CMD_WRITE, 8'h03, 0), ent(CMD_WRITE, 8'h04, 0),
             ent(CMD_STOP, 0, 0)};
    kick(7'h50, 1'b0, 8'd4);
    i = 0;
    while (bytesDone != 8'd2 && i < 200) begin
      tick();
      i++;
    end
    check("mid_byte2", 32'(bytesDone), 2);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #4;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(cmdValid), 0);
    check("mid_rst_bytes", 32'(bytesDone), 0);
    expQ.delete();
    txQ = '{8'h77};
    expQ = '{ent(CMD_START, 0, 0), ent(CMD_WRITE, 8'h42, 0),
             ent(CMD_WRITE, 8'h77, 0), ent(CMD_STOP, 0, 0)};
    base = doneCnt;
    kick(7'h21, 1'b0, 8'd1);
    waitDone(base, "restart");
    check("restart_bytes", 32'(bytesDone), 1);
    check("restart_nack", 32'(nackError), 0);
    check("restart_left", expQ.size(), 0);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_transfer_sequencer.md
Name: i2c_transfer_sequencer

Overview:
Master-side transaction controller between the i2c TX/RX byte FIFOs and the i2c byte engine. On a start request it issues START, address, N data bytes and STOP to the engine one command at a time. Write bytes are pulled from the TX FIFO and read bytes are pushed into the RX FIFO. It stalls on FIFO empty/full, reports slave NACKs, and gives CPU-visible busy/done status.

Parameters:
COUNTWIDTH, 8, width of byteCount/bytesDone; max transfer 2^COUNTWIDTH-1 bytes
DATAWIDTH, 8, byte width of FIFO/engine data (fixed 8 for i2c; parameter for consistency)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  level; request early STOP
slaveAddr  in  7  7-bit target address
readNotWrite  in  1  1 = read transfer, 0 = write
byteCount  in  COUNTWIDTH  data bytes; 0 = address-only probe
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse on the first IDLE cycle after STOP completes
nackError  out  1  sticky; cleared by accepted start
bytesDone  out  COUNTWIDTH  data bytes completed this transfer
txEmpty  in  1  TX FIFO empty
txData  in  DATAWIDTH  TX FIFO head byte, valid whenever !txEmpty
txReadReq  out  1  one-cycle pop of TX FIFO
rxFull  in  1  RX FIFO full
rxWriteEn  out  1  one-cycle push to RX FIFO
rxData  out  DATAWIDTH  byte pushed to RX FIFO
cmdValid  out  1  command offered to engine
cmdReady  in  1  engine accepts command
cmd  out  2  0 START, 1 WRITE, 2 READ, 3 STOP
cmdData  out  DATAWIDTH  byte for WRITE
cmdNackLast  out  1  for READ: master NACKs this byte
rspValid  in  1  one-cycle pulse when the engine finishes the accepted command
rspAck  in  1  slave ACK for WRITE (1 = ACK); don't-care otherwise
rspData  in  DATAWIDTH  received byte for READ

Behaviour:
- Reset (reset==0 at posedge): state IDLE. All outputs 0, including cmd, cmdData, rxData, bytesDone and nackError. Applies mid-transfer with no STOP issued; the engine shares the same reset.
- States: IDLE, START, ADDR, WR_FETCH, WR_CMD, RD_CMD, RD_STORE, STOP, DONE.
- Command handshake: a command transfers on a cycle with cmdValid&&cmdReady. cmd, cmdData and cmdNackLast are held stable while cmdValid is high. After a transfer, cmdValid drops and the FSM waits for rspValid before the next command. Exactly one command is outstanding at a time.
- IDLE: start=1 at edge N -> at N+1 the FSM is in START with cmdValid=1, cmd=START. On that same edge, slaveAddr/readNotWrite/byteCount are latched, and bytesDone and nackError are cleared. start while busy is ignored.
- START rsp -> ADDR: WRITE with cmdData={slaveAddr,readNotWrite}.
- ADDR rsp, rspAck=0: set nackError and go to STOP.
- ADDR rsp, rspAck=1: byteCount==0 -> STOP; readNotWrite=1 -> RD_CMD; otherwise -> WR_FETCH.
- WR_FETCH: wait while txEmpty (no timeout). When !txEmpty: latch txData into cmdData, pulse txReadReq the same cycle, go to WR_CMD.
- WR_CMD: issue WRITE. On rsp: bytesDone+1.
  - rspAck=0 -> nackError=1, go to STOP.
  - bytesDone==byteCount -> STOP.
  - otherwise -> WR_FETCH.
- RD_CMD: issue READ with cmdNackLast=1 only on the final byte. On rsp: latch rspData into rxData, go to RD_STORE.
- RD_STORE: wait while rxFull. When !rxFull: rxWriteEn=1 for one cycle and bytesDone+1. Then go to STOP if this was the last byte, else to RD_CMD.
- Abort: honoured only when the FSM would next issue START/WRITE/READ (also from WR_FETCH while stalled) -> go to STOP. It never cuts a handshake in progress. A read byte already received is still stored first. Abort in IDLE is ignored. nackError is not set by abort.
- STOP: issue STOP. On rsp -> DONE.
- DONE lasts one cycle, then IDLE. done is registered and pulses on the first IDLE cycle; busy=0 on that same cycle.
- bytesDone never wraps: byteCount ≤ 2^COUNTWIDTH-1 by type.

Decomposition:
- Package i2c_seq_pkg holds:
  - i2cCmd_t enum (START/WRITE/READ/STOP, 2 bits);
  - seqState_t enum;
  - the CMD_* constants shared with the byte engine.
- Single module with no sub-module. The FSM, latches and counter are all local.

Test Plan:
- Write 3 bytes to addr 0x50: TX FIFO holds A1,B2,C3, engine always ACKs -> commands START, WRITE 0xA0, WRITE A1, B2, C3, STOP. Three txReadReq pulses; bytesDone=3, done pulse, nackError=0.
- Read 2 bytes from 0x50: engine returns 5A,6B -> address byte 0xA1. First READ has cmdNackLast=0, second has 1. rxWriteEn pushes 5A then 6B; done=1.
- Address NACK, byteCount=4: rspAck=0 on the address -> next command is STOP. nackError=1, bytesDone=0, no txReadReq.
- TX underflow stall: byteCount=2, FIFO empty for 20 cycles after the address -> cmdValid stays low and busy=1. Byte 0x11 arrives -> WRITE 0x11 issued. Then abort asserted while stalled again -> STOP, done, bytesDone=1.
- RX full stall plus cmdReady backpressure: rxFull=1 for 10 cycles -> no rxWriteEn, no further READ. cmdReady low for 5 cycles -> cmd/cmdData held constant.
- Reset mid-transfer after the 2nd write byte: reset=0 for 1 cycle -> next cycle busy=0, cmdValid=0, bytesDone=0. A start on the following cycle begins a new transfer normally.
